// File: rtl/coherence_bus_ctrl_if.sv
// Cache/RAM side bundle of the two-core coherence bus controller.
// Controller uses the slave modport; caches and RAM model the master.
interface coherence_bus_ctrl_if;
  logic [1:0]       iREN;
  logic [1:0][31:0] iaddr;
  logic [1:0]       iwait;
  logic [31:0]      iload;
  logic [1:0]       dREN;
  logic [1:0]       dWEN;
  logic [1:0][31:0] daddr;
  logic [1:0][31:0] dstore;
  logic [1:0]       dwait;
  logic [1:0][31:0] dload;
  logic [1:0]       cctrans;
  logic [1:0]       ccwrite;
  logic [1:0]       ccwait;
  logic [1:0]       ccinv;
  logic [1:0][31:0] ccsnoopaddr;
  logic             ramREN;
  logic             ramWEN;
  logic [31:0]      ramaddr;
  logic [31:0]      ramstore;
  logic [31:0]      ramload;
  logic             ramwait;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore,
    input  cctrans, ccwrite, ramload, ramwait,
    output iwait, iload, dwait, dload,
    output ccwait, ccinv, ccsnoopaddr,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore,
    output cctrans, ccwrite, ramload, ramwait,
    input  iwait, iload, dwait, dload,
    input  ccwait, ccinv, ccsnoopaddr,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/coherence_bus_ctrl.sv
// Two-core coherence/memory controller: arbitration, snoop, c2c, RAM.
// Optional counters snoop_cnt/c2c_cnt/wb_cnt under macro COH_STATS_EN.
module coherence_bus_ctrl #(
  parameter int   SNOOP_LAT = 2,
  parameter logic RR_INIT   = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  coherence_bus_ctrl_if.slave bus
`ifdef COH_STATS_EN
  ,
  output logic [31:0] snoop_cnt,
  output logic [31:0] c2c_cnt,
  output logic [31:0] wb_cnt
`endif
);

  typedef enum logic [3:0] {
    IDLE,
    IFETCH,
    WB0,
    WB1,
    SNOOP,
    C2C0,
    C2C1,
    LD0,
    LD1
  } state_t;

  state_t      state;
  state_t      nstate;
  logic        g;
  logic        ng;
  logic        p;
  logic        rr;
  logic [2:0]  cnt;
  logic [31:0] snp_addr;
  logic        snp_inv;
  logic [1:0]  wb_req;
  logic        last;

  // Tie goes to the round-robin core, otherwise the lone requester.
  function automatic logic pick(
    input logic [1:0] req,
    input logic       pri
  );
    if (&req) return pri;
    return req[1];
  endfunction

  assign p      = ~g;
  assign wb_req = bus.dWEN & ~bus.cctrans;
  assign last   = (cnt == 3'(SNOOP_LAT - 1));

  // State, grant, priority and snoop-latch registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      g        <= 1'b0;
      rr       <= RR_INIT;
      cnt      <= 3'd0;
      snp_addr <= 32'd0;
      snp_inv  <= 1'b0;
    end else begin
      state <= nstate;
      g     <= ng;
      if (state != IDLE && nstate == IDLE)
        rr <= ~g;
      if (state == SNOOP)
        cnt <= cnt + 3'd1;
      else
        cnt <= 3'd0;
      if (state == IDLE && nstate == SNOOP) begin
        snp_addr <= bus.daddr[ng];
        snp_inv  <= bus.ccwrite[ng];
      end
    end
  end

  // Next-state decode and all bus outputs for the current state.
  always_comb begin
    nstate          = state;
    ng              = g;
    bus.iwait       = bus.iREN;
    bus.dwait       = bus.dREN | bus.dWEN;
    bus.iload       = 32'd0;
    bus.dload       = '0;
    bus.ccwait      = 2'b00;
    bus.ccinv       = 2'b00;
    bus.ccsnoopaddr = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = 32'd0;
    bus.ramstore    = 32'd0;
    case (state)
      IDLE: begin
        if (|wb_req) begin
          ng     = pick(wb_req, rr);
          nstate = WB0;
        end else if (|bus.cctrans) begin
          ng     = pick(bus.cctrans, rr);
          nstate = SNOOP;
        end else if (|bus.iREN) begin
          ng     = pick(bus.iREN, rr);
          nstate = IFETCH;
        end
      end
      IFETCH: begin
        bus.ramREN   = 1'b1;
        bus.ramaddr  = bus.iaddr[g];
        bus.iload    = bus.ramload;
        bus.iwait[g] = bus.ramwait;
        if (!bus.ramwait)
          nstate = IDLE;
      end
      WB0, WB1: begin
        bus.ramWEN   = 1'b1;
        bus.ramaddr  = bus.daddr[g];
        bus.ramstore = bus.dstore[g];
        bus.dwait[g] = bus.ramwait;
        if (!bus.ramwait)
          nstate = (state == WB0) ? WB1 : IDLE;
      end
      SNOOP: begin
        bus.ccwait[p]      = 1'b1;
        bus.ccsnoopaddr[p] = snp_addr;
        bus.ccinv[p]       = snp_inv;
        if (last) begin
          if (bus.ccwrite[p]) begin
            nstate = C2C0;
          end else if (bus.dREN[g]) begin
            nstate = LD0;
          end else begin
            nstate       = IDLE;
            bus.dwait[g] = 1'b0;
          end
        end
      end
      C2C0, C2C1: begin
        bus.ccwait[p] = 1'b1;
        bus.ramWEN    = 1'b1;
        bus.ramaddr   = bus.daddr[p];
        bus.ramstore  = bus.dstore[p];
        bus.dload[g]  = bus.dstore[p];
        bus.dwait[p]  = bus.ramwait;
        bus.dwait[g]  = bus.ramwait;
        if (!bus.ramwait)
          nstate = (state == C2C0) ? C2C1 : IDLE;
      end
      LD0, LD1: begin
        bus.ramREN   = 1'b1;
        bus.ramaddr  = bus.daddr[g];
        bus.dload[g] = bus.ramload;
        bus.dwait[g] = bus.ramwait;
        if (!bus.ramwait)
          nstate = (state == LD0) ? LD1 : IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

`ifdef COH_STATS_EN
  // Event counters: snoop entries, completed c2c lines, completed writebacks.
  always_ff @(posedge CLK) begin
    if (RST) begin
      snoop_cnt <= 32'd0;
      c2c_cnt   <= 32'd0;
      wb_cnt    <= 32'd0;
    end else begin
      if (state == IDLE && nstate == SNOOP)
        snoop_cnt <= snoop_cnt + 32'd1;
      if (state == C2C1 && !bus.ramwait)
        c2c_cnt <= c2c_cnt + 32'd1;
      if (state == WB1 && !bus.ramwait)
        wb_cnt <= wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Scoreboard bench for coherence_bus_ctrl: RAM model with programmable
// wait, expected RAM transfers queued at stimulus time, checked on completion.
module tb_coherence_bus_ctrl;

  localparam logic [31:0] KEY = 32'h5A5A_0000;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          sel;
    logic [3:0]  wt;
    logic [1:0]  ccw;
    int          hold;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ncmp  = 0;
  int   cyc   = 0;
  int   ram_lat = 0;
  int   wcnt  = 0;
  exp_t sb[$];
  exp_t it;

  always #5 CLK = ~CLK;

  coherence_bus_ctrl_if bus();

`ifdef COH_STATS_EN
  logic [31:0] snoop_cnt;
  logic [31:0] c2c_cnt;
  logic [31:0] wb_cnt;
`endif

  coherence_bus_ctrl #(
    .SNOOP_LAT(2),
    .RR_INIT(1'b0)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef COH_STATS_EN
    ,
    .snoop_cnt(snoop_cnt),
    .c2c_cnt(c2c_cnt),
    .wb_cnt(wb_cnt)
`endif
  );

  assign bus.ramwait = (wcnt < ram_lat);
  assign bus.ramload = bus.ramaddr ^ KEY;

  always @(posedge CLK) begin
    if ((bus.ramREN | bus.ramWEN) && bus.ramwait)
      wcnt <= wcnt + 1;
    else
      wcnt <= 0;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void push(
    input logic        we,
    input logic [31:0] addr,
    input logic [31:0] data,
    input int          sel,
    input logic [3:0]  wt,
    input logic [1:0]  ccw,
    input int          hold
  );
    exp_t e;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    e.sel  = sel;
    e.wt   = wt;
    e.ccw  = ccw;
    e.hold = hold;
    sb.push_back(e);
  endfunction

  // RAM-side monitor: stall cycles follow the default waits,
  // completions are popped from the scoreboard and compared.
  always @(negedge CLK) begin
    if (RST) begin
      cyc = 0;
    end else if (bus.ramREN | bus.ramWEN) begin
      cyc++;
      if (bus.ramwait) begin
        chk("stall_iwait", 32'(bus.iwait), 32'(bus.iREN));
        chk("stall_dwait", 32'(bus.dwait), 32'(bus.dREN | bus.dWEN));
      end else begin
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          it = sb.pop_front();
          chk("ram_we", 32'(bus.ramWEN), 32'(it.we));
          chk("ram_ren", 32'(bus.ramREN), 32'(!it.we));
          chk("ram_addr", bus.ramaddr, it.addr);
          if (it.we)
            chk("ram_store", bus.ramstore, it.data);
          if (it.sel == 1)
            chk("iload", bus.iload, it.data);
          if (it.sel == 2)
            chk("dload0", bus.dload[0], it.data);
          if (it.sel == 3)
            chk("dload1", bus.dload[1], it.data);
          chk("waits", 32'({bus.iwait, bus.dwait}), 32'(it.wt));
          chk("ccwait_xfer", 32'(bus.ccwait), 32'(it.ccw));
          chk("hold", 32'(cyc), 32'(it.hold));
        end
        cyc = 0;
        ncmp++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_cmp(input int n);
    int b;
    b = 0;
    while (ncmp < n && b < 200) begin
      @(negedge CLK);
      #1;
      b++;
    end
    chk("progress", 32'(ncmp), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.iREN    = 2'b01;
    bus.iaddr   = '0;
    bus.dREN    = 2'b00;
    bus.dWEN    = 2'b00;
    bus.daddr   = '0;
    bus.dstore  = '0;
    bus.cctrans = 2'b00;
    bus.ccwrite = 2'b00;

    // Reset: nothing granted, all outputs idle.
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_strobes", 32'({bus.ramREN, bus.ramWEN}), 0);
    chk("rst_ccwait", 32'(bus.ccwait), 0);
    chk("rst_ccinv", 32'(bus.ccinv), 0);
    chk("rst_snpaddr", bus.ccsnoopaddr[1], 0);
    chk("rst_iload", bus.iload, 0);
    chk("rst_dload", bus.dload[0] | bus.dload[1], 0);
    chk("rst_iwait", 32'(bus.iwait), 32'h1);
    bus.iREN = 2'b00;
    RST = 1'b0;

    // Dual fetch: core0 first, then core1 via round-robin.
    tick();
    bus.iaddr[0] = 32'h100;
    bus.iaddr[1] = 32'h200;
    bus.iREN     = 2'b11;
    push(0, 32'h100, 32'h100 ^ KEY, 1, 4'b1000, 2'b00, 1);
    push(0, 32'h200, 32'h200 ^ KEY, 1, 4'b0100, 2'b00, 1);
    wait_cmp(2);
    bus.iREN = 2'b00;

    // Coherent miss, clean peer: 2-cycle snoop then RAM load.
    tick();
    bus.dREN[0]    = 1'b1;
    bus.cctrans[0] = 1'b1;
    bus.daddr[0]   = 32'h40;
    push(0, 32'h40, 32'h40 ^ KEY, 2, 4'b0000, 2'b00, 1);
    push(0, 32'h44, 32'h44 ^ KEY, 2, 4'b0000, 2'b00, 1);
    tick();
    chk("snp_ccwait0", 32'(bus.ccwait), 32'h2);
    chk("snp_addr", bus.ccsnoopaddr[1], 32'h40);
    chk("snp_inv", 32'(bus.ccinv), 0);
    chk("snp_noram", 32'({bus.ramREN, bus.ramWEN}), 0);
    chk("snp_dwait", 32'(bus.dwait), 32'h1);
    tick();
    chk("snp_ccwait1", 32'(bus.ccwait), 32'h2);
    tick();
    chk("ld_ccwait", 32'(bus.ccwait), 0);
    chk("ld_ren", 32'(bus.ramREN), 1);
    wait_cmp(3);
    bus.daddr[0] = 32'h44;
    wait_cmp(4);
    bus.dREN    = 2'b00;
    bus.cctrans = 2'b00;

    // Coherent miss, dirty peer: cache-to-cache with RAM writeback.
    tick();
    bus.dREN[0]    = 1'b1;
    bus.cctrans[0] = 1'b1;
    bus.daddr[0]   = 32'h40;
    push(1, 32'h40, 32'hAAAA, 2, 4'b0000, 2'b10, 1);
    push(1, 32'h44, 32'hBBBB, 2, 4'b0000, 2'b10, 1);
    tick();
    bus.ccwrite[1] = 1'b1;
    bus.dWEN[1]    = 1'b1;
    bus.daddr[1]   = 32'h40;
    bus.dstore[1]  = 32'hAAAA;
    wait_cmp(5);
    bus.daddr[1]  = 32'h44;
    bus.dstore[1] = 32'hBBBB;
    wait_cmp(6);
    bus.dREN    = 2'b00;
    bus.dWEN    = 2'b00;
    bus.cctrans = 2'b00;
    bus.ccwrite = 2'b00;

    // Upgrade (invalidate-only) from core1: no RAM traffic.
    tick();
    bus.cctrans[1] = 1'b1;
    bus.ccwrite[1] = 1'b1;
    bus.daddr[1]   = 32'h80;
    tick();
    chk("upg_ccwait", 32'(bus.ccwait), 32'h1);
    chk("upg_ccinv", 32'(bus.ccinv), 32'h1);
    chk("upg_addr", bus.ccsnoopaddr[0], 32'h80);
    tick();
    chk("upg_ccinv_last", 32'(bus.ccinv), 32'h1);
    chk("upg_dwait", 32'(bus.dwait), 0);
    chk("upg_noram", 32'({bus.ramREN, bus.ramWEN}), 0);
    bus.cctrans = 2'b00;
    bus.ccwrite = 2'b00;
    tick();
    chk("upg_done", 32'({bus.ccwait, bus.ccinv}), 0);

    // Reset in LD1 aborts; the repeated request starts over.
    ram_lat = 1;
    bus.dREN[0]    = 1'b1;
    bus.cctrans[0] = 1'b1;
    bus.daddr[0]   = 32'h40;
    push(0, 32'h40, 32'h40 ^ KEY, 2, 4'b0000, 2'b00, 2);
    wait_cmp(7);
    bus.daddr[0] = 32'h44;
    tick();
    chk("ld1_ren", 32'(bus.ramREN), 1);
    chk("ld1_addr", bus.ramaddr, 32'h44);
    RST = 1'b1;
    tick();
    chk("abort_strobes", 32'({bus.ramREN, bus.ramWEN}), 0);
    chk("abort_dload", bus.dload[0], 0);
    chk("abort_dwait", 32'(bus.dwait), 32'h1);
    bus.daddr[0] = 32'h40;
    push(0, 32'h40, 32'h40 ^ KEY, 2, 4'b0000, 2'b00, 2);
    push(0, 32'h44, 32'h44 ^ KEY, 2, 4'b0000, 2'b00, 2);
    RST = 1'b0;
    wait_cmp(8);
    bus.daddr[0] = 32'h44;
    wait_cmp(9);
    bus.dREN    = 2'b00;
    bus.cctrans = 2'b00;

    // Writeback with 3 wait cycles per word.
    tick();
    ram_lat = 3;
    bus.dWEN[0]   = 1'b1;
    bus.daddr[0]  = 32'h80;
    bus.dstore[0] = 32'h1111;
    push(1, 32'h80, 32'h1111, 0, 4'b0000, 2'b00, 4);
    push(1, 32'h84, 32'h2222, 0, 4'b0000, 2'b00, 4);
    wait_cmp(10);
    bus.daddr[0]  = 32'h84;
    bus.dstore[0] = 32'h2222;
    wait_cmp(11);
    bus.dWEN = 2'b00;
    tick();
    tick();
    chk("end_idle", 32'({bus.ramREN, bus.ramWEN}), 0);

`ifdef COH_STATS_EN
    chk("snoop_cnt", snoop_cnt, 1);
    chk("c2c_cnt", c2c_cnt, 0);
    chk("wb_cnt", wb_cnt, 1);
`endif

    chk("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
